// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (C = CPU, P = peripheral/DMA), the
// arbiter, and BlockRam port B. The slave modport is the arbiter's view.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              c_req, c_lock, c_we, c_gnt, c_rvalid;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata, c_rdata;
   logic              p_req, p_lock, p_we, p_gnt, p_rvalid;
   logic [ADDR_W-1:0] p_addr;
   logic [DATA_W-1:0] p_wdata, p_rdata;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;

   modport slave (
      input  c_req, c_lock, c_we, c_addr, c_wdata,
      input  p_req, p_lock, p_we, p_addr, p_wdata,
      input  mem_rdata,
      output c_gnt, c_rvalid, c_rdata,
      output p_gnt, p_rvalid, p_rdata,
      output mem_we, mem_addr, mem_wdata
   );

   modport master (
      output c_req, c_lock, c_we, c_addr, c_wdata,
      output p_req, p_lock, p_we, p_addr, p_wdata,
      output mem_rdata,
      input  c_gnt, c_rvalid, c_rdata,
      input  p_gnt, p_rvalid, p_rdata,
      input  mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-way arbiter for BlockRam port B: CPU priority with a starvation guard for P,
// bounded locked runs, read-data routing. DMEM_ARB_ROUND_ROBIN_EN selects round-robin.
module dmem_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 8,
   parameter int LOCK_MAX = 4
) (
   input  logic          CLK_50MHZ,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_LOCK_C, S_LOCK_P} state_t;

   state_t     r_state, w_next;
   logic [3:0] r_lock_cnt, w_lock_cnt_nxt, w_run;
   logic       w_gnt_c, w_gnt_p;
   logic       r_rvalid_c, r_rvalid_p;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   logic r_last_p;

   always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset)       r_last_p <= 1'b1;
      else if (w_gnt_c) r_last_p <= 1'b0;
      else if (w_gnt_p) r_last_p <= 1'b1;
   end
`else
   logic [3:0] r_wait_cnt;
   logic       w_starve;

   assign w_starve = (r_wait_cnt == 4'(MAX_WAIT));

   always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset)                       r_wait_cnt <= '0;
      else if (bus.p_req && !w_gnt_p) begin
         if (!w_starve)                 r_wait_cnt <= r_wait_cnt + 4'd1;
      end
      else                              r_wait_cnt <= '0;
   end
`endif

   always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_lock_cnt <= '0;
      end else begin
         r_state    <= w_next;
         r_lock_cnt <= w_lock_cnt_nxt;
      end
   end

   // r_lock_cnt counts grants already issued in the current run; the
   // LOCK_MAX-th grant of a run always releases ownership.
   always_comb begin
      w_next         = S_IDLE;
      w_lock_cnt_nxt = '0;
      w_run          = '0;
      if (w_gnt_c && bus.c_lock) begin
         w_run = (r_state == S_LOCK_C) ? r_lock_cnt + 4'd1 : 4'd1;
         if (w_run < 4'(LOCK_MAX)) begin
            w_next         = S_LOCK_C;
            w_lock_cnt_nxt = w_run;
         end
      end else if (w_gnt_p && bus.p_lock) begin
         w_run = (r_state == S_LOCK_P) ? r_lock_cnt + 4'd1 : 4'd1;
         if (w_run < 4'(LOCK_MAX)) begin
            w_next         = S_LOCK_P;
            w_lock_cnt_nxt = w_run;
         end
      end
   end

   always_comb begin
      w_gnt_c = 1'b0;
      w_gnt_p = 1'b0;
      case (r_state)
         S_LOCK_C: w_gnt_c = bus.c_req;
         S_LOCK_P: w_gnt_p = bus.p_req;
         default: begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            if (bus.c_req && bus.p_req) begin
               w_gnt_c = r_last_p;
               w_gnt_p = !r_last_p;
            end else begin
               w_gnt_c = bus.c_req;
               w_gnt_p = bus.p_req;
            end
`else
            if (w_starve && bus.p_req) w_gnt_p = 1'b1;
            else if (bus.c_req)        w_gnt_c = 1'b1;
            else                       w_gnt_p = bus.p_req;
`endif
         end
      endcase
      // No access may be issued while reset is held, even mid-cycle.
      if (!reset) begin
         w_gnt_c = 1'b0;
         w_gnt_p = 1'b0;
      end
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (w_gnt_c) begin
         bus.mem_we    = bus.c_we;
         bus.mem_addr  = bus.c_addr;
         bus.mem_wdata = bus.c_wdata;
      end else if (w_gnt_p) begin
         bus.mem_we    = bus.p_we;
         bus.mem_addr  = bus.p_addr;
         bus.mem_wdata = bus.p_wdata;
      end
   end

   always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset) begin
         r_rvalid_c <= 1'b0;
         r_rvalid_p <= 1'b0;
      end else begin
         r_rvalid_c <= w_gnt_c && !bus.c_we;
         r_rvalid_p <= w_gnt_p && !bus.p_we;
      end
   end

   assign bus.c_gnt    = w_gnt_c;
   assign bus.p_gnt    = w_gnt_p;
   assign bus.c_rvalid = r_rvalid_c;
   assign bus.p_rvalid = r_rvalid_p;
   assign bus.c_rdata  = bus.mem_rdata;
   assign bus.p_rdata  = bus.mem_rdata;
endmodule
